garage_occupancy_ctrl: RTL and testbench

Clocked, parametrised occupancy controller for the car-garage design.
- Synchronises raw car_in/car_out sensor levels and converts rising edges into single-cycle events.
- Maintains a saturating occupancy count against a configurable CAPACITY and drives an entry gate with a timed open window.
- Provides full/empty/reject/error status and registered BCD digits for the two 7-segment decoders downstream.

---
 rtl/garage_occupancy_ctrl.sv | 84 ++++++++
 tb/tb_garage_occupancy_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/garage_occupancy_ctrl.sv
// garage_occupancy_ctrl: synchronised car sensors driving a saturating occupancy count,
// a timed entry gate, full/empty/reject/error status and registered BCD digits.
module garage_occupancy_ctrl #(
    parameter int CAPACITY    = 50,
    parameter int CNT_W       = 6,
    parameter int SYNC_STAGES = 2,
    parameter int GATE_TIME   = 16,
    parameter int TMR_W       = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             car_in,
    input  logic             car_out,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             gate_open,
    output logic             reject,
    output logic             out_err,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);
    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;
    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] in_sync_q, out_sync_q;
    logic                   in_prev_q, out_prev_q;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic                   reject_q, reject_d, out_err_q, out_err_d;
    logic [3:0]             tens_q, ones_q;
    logic                   in_evt, out_evt, not_empty, accept_in, do_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_sync_q  <= '0;
            out_sync_q <= '0;
            in_prev_q  <= 1'b0;
            out_prev_q <= 1'b0;
            count_q    <= '0;
            state_q    <= EMPTY;
            tmr_q      <= '0;
            reject_q   <= 1'b0;
            out_err_q  <= 1'b0;
            tens_q     <= '0;
            ones_q     <= '0;
        end else begin
            in_sync_q  <= {in_sync_q[SYNC_STAGES-2:0], car_in};
            out_sync_q <= {out_sync_q[SYNC_STAGES-2:0], car_out};
            in_prev_q  <= in_sync_q[SYNC_STAGES-1];
            out_prev_q <= out_sync_q[SYNC_STAGES-1];
            count_q    <= count_d;
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            reject_q   <= reject_d;
            out_err_q  <= out_err_d;
            tens_q     <= 4'(int'(count_q) / 10);
            ones_q     <= 4'(int'(count_q) % 10);
        end
    end

    // A simultaneous exit frees a slot, so a full garage can still accept an entry.
    always_comb begin
        in_evt    = in_sync_q[SYNC_STAGES-1] & ~in_prev_q;
        out_evt   = out_sync_q[SYNC_STAGES-1] & ~out_prev_q;
        not_empty = count_q != '0;
        accept_in = in_evt & enable & ((count_q < CNT_W'(CAPACITY)) | (out_evt & not_empty));
        do_out    = out_evt & not_empty;
        count_d   = count_q + CNT_W'(accept_in) - CNT_W'(do_out);
        reject_d  = in_evt & ~accept_in;
        out_err_d = out_evt & ~not_empty & ~accept_in;
        tmr_d     = accept_in ? TMR_W'(GATE_TIME) : (tmr_q != '0 ? tmr_q - TMR_W'(1) : tmr_q);
        state_d   = count_d == '0 ? EMPTY : (count_d == CNT_W'(CAPACITY) ? FULL : PARTIAL);
    end

    assign count     = count_q;
    assign full      = state_q == FULL;
    assign empty     = state_q == EMPTY;
    assign gate_open = tmr_q != '0;
    assign reject    = reject_q;
    assign out_err   = out_err_q;
    assign tens      = tens_q;
    assign ones      = ones_q;
endmodule

// File: tb/tb_garage_occupancy_ctrl.sv
// tb_garage_occupancy_ctrl: directed checks of counting, saturation, simultaneous events,
// gate timing, BCD digits and asynchronous reset.
module tb_garage_occupancy_ctrl;
    logic       clk = 1'b0, reset_n = 1'b0, enable = 1'b1, car_in = 1'b0, car_out = 1'b0;
    logic [5:0] count;
    logic       full, empty, gate_open, reject, out_err;
    logic [3:0] tens, ones;
    int         checks = 0, errors = 0;
    int         glen, high;

    garage_occupancy_ctrl dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .car_in(car_in), .car_out(car_out),
        .count(count), .full(full), .empty(empty), .gate_open(gate_open),
        .reject(reject), .out_err(out_err), .tens(tens), .ones(ones)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic i, input logic o, input int hi, input int lo);
        car_in  = i;
        car_out = o;
        step(hi);
        car_in  = 1'b0;
        car_out = 1'b0;
        step(lo);
    endtask

    // Entry pulse that also measures how many sampled cycles the gate stays open.
    task automatic entry_gate(output int len);
        car_in = 1'b1;
        step(3);
        len = 0;
        while (gate_open && len < 100) begin
            len++;
            if (len == 3) car_in = 1'b0;
            step(1);
        end
        car_in = 1'b0;
        step(3);
    endtask

    initial begin
        step(2);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_gate", gate_open, 0);
        chk("rst_reject", reject, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_tens", tens, 0);
        chk("rst_ones", ones, 0);
        @(negedge clk) reset_n = 1'b1;
        step(1);

        car_in = 1'b1;
        step(2);
        chk("latency_not_yet", count, 0);
        step(1);
        chk("latency_count", count, 1);
        chk("latency_gate", gate_open, 1);
        car_in = 1'b0;
        step(20);
        for (int k = 0; k < 4; k++) begin
            entry_gate(glen);
            chk("gate_len16", glen, 16);
        end
        step(1);
        chk("five_count", count, 5);
        chk("five_tens", tens, 0);
        chk("five_ones", ones, 5);
        chk("five_empty", empty, 0);

        car_in = 1'b1;
        step(40);
        car_in = 1'b0;
        step(5);
        chk("held_once", count, 6);

        for (int k = 0; k < 44; k++) pulse(1'b1, 1'b0, 3, 3);
        chk("fill_count", count, 50);
        chk("fill_full", full, 1);
        step(20);
        chk("fill_tens", tens, 5);
        chk("fill_ones", ones, 0);
        chk("fill_gate_closed", gate_open, 0);

        car_in = 1'b1;
        step(3);
        chk("over_reject", reject, 1);
        chk("over_count", count, 50);
        chk("over_gate", gate_open, 0);
        step(1);
        chk("over_reject_1cyc", reject, 0);
        chk("over_gate_later", gate_open, 0);
        car_in = 1'b0;
        step(3);

        car_in = 1'b1;
        car_out = 1'b1;
        step(3);
        chk("both_full_count", count, 50);
        chk("both_full_reject", reject, 0);
        chk("both_full_gate", gate_open, 1);
        chk("both_full_full", full, 1);
        car_in = 1'b0;
        car_out = 1'b0;
        step(20);

        enable = 1'b0;
        car_in = 1'b1;
        car_out = 1'b1;
        step(3);
        chk("both_dis_count", count, 49);
        chk("both_dis_reject", reject, 1);
        chk("both_dis_full", full, 0);
        chk("both_dis_gate", gate_open, 0);
        car_in = 1'b0;
        car_out = 1'b0;
        step(3);
        enable = 1'b1;

        for (int k = 0; k < 49; k++) pulse(1'b0, 1'b1, 3, 3);
        chk("drain_count", count, 0);
        chk("drain_empty", empty, 1);
        step(20);

        car_out = 1'b1;
        step(3);
        chk("err_pulse", out_err, 1);
        chk("err_count", count, 0);
        step(1);
        chk("err_1cyc", out_err, 0);
        car_out = 1'b0;
        step(3);

        car_in = 1'b1;
        car_out = 1'b1;
        step(3);
        chk("both_empty_count", count, 1);
        chk("both_empty_err", out_err, 0);
        chk("both_empty_full", full, 0);
        car_in = 1'b0;
        car_out = 1'b0;
        step(20);

        car_in = 1'b1;
        high = 0;
        for (int k = 1; k <= 60; k++) begin
            step(1);
            if (gate_open) high++;
            if (k == 3 || k == 13) car_in = 1'b0;
            if (k == 10) car_in = 1'b1;
        end
        chk("extend_len26", high, 26);
        chk("extend_count", count, 3);

        for (int k = 0; k < 34; k++) pulse(1'b1, 1'b0, 3, 3);
        step(1);
        chk("pre_rst_count", count, 37);
        chk("pre_rst_gate", gate_open, 1);
        chk("pre_rst_tens", tens, 3);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_gate", gate_open, 0);
        chk("arst_empty", empty, 1);
        chk("arst_tens", tens, 0);
        chk("arst_ones", ones, 0);
        @(negedge clk) reset_n = 1'b1;
        step(1);
        car_in = 1'b1;
        step(3);
        chk("post_rst_count", count, 1);
        step(1);
        chk("post_rst_ones", ones, 1);
        car_in = 1'b0;
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
